tdpram_bank: RTL and testbench
==============================

# tdpram_bank

Parametrised true dual-port RAM bank for the matrix engine's row storage, successor to the fixed 256×32 dual-port RAM. It adds per-byte write enables, explicit read enables with a `q_*_valid` flag and an optional output pipeline register. It also provides defined same-address collision rules and a hardware zero-initialisation sequencer that runs after reset or on request. Sits between the matrix load/store controller and the compute array; both ports are independent masters on one clock.

## Interface
- `DATA_W`, 256, word width in bits; must be a multiple of 8
- `DEPTH`, 32, number of words; any value ≥ 2, not necessarily a power of two
- `ADDR_W`, `$clog2(DEPTH)`, address width
- `OUT_REG`, 1, 1 = extra output register stage; 0 = none
- `NB`, `DATA_W/8`, byte lanes (derived, not overridable)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous request to re-zero the whole array
- `init_done`  out  1  high when the bank accepts port traffic
- `en_a`, `en_b`  in  1  port access enable
- `wen_a`, `wen_b`  in  1  write (1) / read (0), qualified by `en_*`
- `be_a`, `be_b`  in  NB  byte write enables; bit i covers `d[8i+7:8i]`
- `addr_a`, `addr_b`  in  ADDR_W  word address
- `d_a`, `d_b`  in  DATA_W  write data
- `q_a`, `q_b`  out  DATA_W  read data
- `q_a_valid`, `q_b_valid`  out  1  `q_*` carries a fresh read result this cycle
- `coll`  out  1  one-cycle pulse marking a same-address collision
- `oob`  out  1  one-cycle pulse marking an access with `addr ≥ DEPTH`

## Operation
- FSM states: INIT and READY.
  - Reset enters INIT with `init_cnt`=0.
  - INIT writes zero to word `init_cnt` each cycle and increments it. After writing word DEPTH−1 the FSM moves to READY.
  - `clr`=1 in READY moves to INIT with `init_cnt`=0. `clr` in INIT restarts the count at 0.
- `init_done` = (state == READY). In INIT all port enables are ignored: no writes, no `q_*_valid`, no `coll`.
- Write: `en`=1, `wen`=1. Only byte lanes with `be[i]`=1 are updated. `be`=0 means no write.
- Read: `en`=1, `wen`=0. `be` is ignored.
- Same-port read-during-write does not occur, because a port either reads or writes in a given cycle.
- Cross-port, same address, both writing: for each byte lane, port A wins where `be_a[i]`=1; otherwise port B's lane is written if `be_b[i]`=1. `coll` pulses.
- Cross-port, same address, one reading and one writing: read-first. The reader returns the pre-write contents, and `coll` pulses.
- Both ports reading the same address: no collision, and `coll` stays 0.
- `addr ≥ DEPTH`: the write is dropped. A read returns 0 with `q_*_valid`=1, and `oob` pulses.
- Memory contents are not reset by `rst_n` directly. They are zeroed by INIT.

## Timing
- Read latency from the enable edge to `q_*_valid`: 1 cycle with `OUT_REG`=0, 2 cycles with `OUT_REG`=1.
- Read throughput is one read per port per cycle with back-to-back enables.
- `q_*` holds its last value when `q_*_valid`=0.
- A write is visible to a read issued on the next cycle, from either port.
- `coll` and `oob` are registered and asserted 1 cycle after the offending access, independent of `OUT_REG`.
- `init_done` rises exactly DEPTH cycles after `rst_n` deasserts, or DEPTH cycles after the `clr` cycle.
- Reset values: `q_a`=`q_b`=0, `q_*_valid`=0, `coll`=0, `oob`=0, `init_done`=0, state=INIT.
- Asserting `rst_n` mid-operation or mid-INIT immediately clears all outputs and pipeline valids. In-flight reads are discarded.
- `clr` while reads are in flight: reads already issued complete with the pre-clear data, and `q_*_valid` still asserts for them.

## Structure
- Package `tdpram_pkg` holds:
  - the `tdpram_state_e` enum (INIT, READY);
  - the byte-lane width constant `BYTE_W`=8;
  - the helper function `be_merge(old, new, be)` used for lane-masked writes.
- Sub-module `tdpram_rd_pipe` is instantiated once per port. It is the optional `OUT_REG` stage carrying data and valid with `rst_n` clear.
- The array is a single `logic [DATA_W-1:0] mem [DEPTH]`, written in one `always_ff` with A-over-B lane priority.

## Test plan
- Reset then idle: `init_done` rises at cycle 32 (default DEPTH). Reads of addr 0–31 return 0 with `q_*_valid` after the configured latency.
- Write A addr 1 = 1337 and B addr 3 = 2022, `be` all-ones, then read A addr 3 and B addr 1 → `q_a`=2022 and `q_b`=1337. `coll`=0.
- Both ports write addr 4 with `be_a`=lower half, `d_a`=all-0xAA, `be_b`=all-ones, `d_b`=all-0x55. Read → lower half 0xAA bytes, upper half 0x55 bytes, `coll` pulses once.
- Port A writes 2023 to addr 2 (holding 1338) while port B reads addr 2 → `q_b`=1338 and `coll` pulses. The next read of addr 2 → 2023.
- Read addr 32 with DEPTH=32 → `q`=0 with `q_*_valid`=1 and `oob` pulses. A write to addr 32 leaves addr 0 unchanged.
- Run with `OUT_REG`=0 and `OUT_REG`=1 to check latency.
- Assert `clr` after writes, and separately drop `rst_n` mid-INIT. In both cases `init_done` falls, port traffic is ignored for 32 cycles, and all words read 0 afterwards.

Source files
------------

// File: rtl/tdpram_pkg.sv
// Shared types and helpers for the true dual-port RAM bank.
// Holds the sequencer state enum, the byte-lane width and the lane-merge helper.
package tdpram_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } tdpram_state_e;

  function automatic logic [BYTE_W-1:0] be_merge(input logic [BYTE_W-1:0] old_lane,
                                                 input logic [BYTE_W-1:0] new_lane,
                                                 input logic              be);
    return be ? new_lane : old_lane;
  endfunction

endpackage

// File: rtl/tdpram_bank_if.sv
// Port A / port B access bus of the RAM bank, plus the collision and out-of-range flags.
interface tdpram_bank_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned NB = DATA_W / 8;

  logic              en_a;
  logic              wen_a;
  logic [NB-1:0]     be_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] d_a;
  logic [DATA_W-1:0] q_a;
  logic              q_a_valid;

  logic              en_b;
  logic              wen_b;
  logic [NB-1:0]     be_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] d_b;
  logic [DATA_W-1:0] q_b;
  logic              q_b_valid;

  logic              coll;
  logic              oob;

  modport master (
    output en_a, wen_a, be_a, addr_a, d_a,
    output en_b, wen_b, be_b, addr_b, d_b,
    input  q_a, q_a_valid, q_b, q_b_valid, coll, oob
  );

  modport slave (
    input  en_a, wen_a, be_a, addr_a, d_a,
    input  en_b, wen_b, be_b, addr_b, d_b,
    output q_a, q_a_valid, q_b, q_b_valid, coll, oob
  );

endinterface

// File: rtl/tdpram_rd_pipe.sv
// Optional output register stage for one read port; data holds while no fresh result arrives.
module tdpram_rd_pipe #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned OUT_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] d_i,
  input  logic              v_i,
  output logic [DATA_W-1:0] q_o,
  output logic              v_o
);

  if (OUT_REG != 0) begin : g_reg
    logic [DATA_W-1:0] q_q;
    logic              v_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_q <= '0;
        v_q <= 1'b0;
      end else begin
        v_q <= v_i;
        if (v_i) begin
          q_q <= d_i;
        end
      end
    end

    assign q_o = q_q;
    assign v_o = v_q;
  end else begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
    assign v_o = v_i;
  end

endmodule

// File: rtl/tdpram_bank.sv
// Parametrised true dual-port RAM bank with byte enables, read-first collisions, out-of-range
// flagging and a zero-initialisation sequencer that runs after reset or on clr_i.
module tdpram_bank
  import tdpram_pkg::*;
#(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned OUT_REG = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  output logic         init_done_o,
  tdpram_bank_if.slave bus
);

  localparam int unsigned     NB       = DATA_W / BYTE_W;
  localparam int unsigned     IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  tdpram_state_e    state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic             ready, init_wr;

  logic              in_a, in_b, acc_a, acc_b, wr_a, wr_b, rd_a, rd_b, same_ww;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [DATA_W-1:0] old_a, old_b, wdat_a, wdat_b;
  logic [DATA_W-1:0] rdat_a_q, rdat_b_q;
  logic              rv_a_q, rv_b_q, coll_q, oob_q;

  // Sequencer: INIT zeroes one word per cycle, clr_i restarts from word 0 in either state.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_wr    = 1'b0;
    unique case (state_q)
      StInit: begin
        init_wr = 1'b1;
        if (clr_i) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == LAST_IDX) begin
          init_cnt_d = '0;
          state_d    = StReady;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (clr_i) begin
          init_cnt_d = '0;
          state_d    = StInit;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign ready       = (state_q == StReady);
  assign init_done_o = ready;

  assign in_a    = ({1'b0, bus.addr_a} < DEPTH_W);
  assign in_b    = ({1'b0, bus.addr_b} < DEPTH_W);
  assign idx_a   = in_a ? IDX_W'(bus.addr_a) : '0;
  assign idx_b   = in_b ? IDX_W'(bus.addr_b) : '0;
  assign acc_a   = ready & bus.en_a;
  assign acc_b   = ready & bus.en_b;
  assign wr_a    = acc_a & bus.wen_a & in_a;
  assign wr_b    = acc_b & bus.wen_b & in_b;
  assign rd_a    = acc_a & ~bus.wen_a;
  assign rd_b    = acc_b & ~bus.wen_b;
  assign same_ww = wr_a & wr_b & (bus.addr_a == bus.addr_b);
  assign old_a   = mem[idx_a];
  assign old_b   = mem[idx_b];

  // On a write/write collision port A's word is built on top of B's, so A wins per lane.
  always_comb begin
    wdat_a = '0;
    wdat_b = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wdat_b[i*BYTE_W +: BYTE_W] = be_merge(old_b[i*BYTE_W +: BYTE_W],
                                            bus.d_b[i*BYTE_W +: BYTE_W], bus.be_b[i]);
      wdat_a[i*BYTE_W +: BYTE_W] = be_merge(same_ww ? wdat_b[i*BYTE_W +: BYTE_W]
                                                    : old_a[i*BYTE_W +: BYTE_W],
                                            bus.d_a[i*BYTE_W +: BYTE_W], bus.be_a[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_wr) begin
      mem[init_cnt_q] <= '0;
    end
    if (wr_b && !same_ww) begin
      mem[idx_b] <= wdat_b;
    end
    if (wr_a) begin
      mem[idx_a] <= wdat_a;
    end
  end

  // Read data is sampled from the pre-write array contents, giving read-first collisions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdat_a_q <= '0;
      rdat_b_q <= '0;
      rv_a_q   <= 1'b0;
      rv_b_q   <= 1'b0;
      coll_q   <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      rv_a_q <= rd_a;
      rv_b_q <= rd_b;
      if (rd_a) begin
        rdat_a_q <= in_a ? old_a : '0;
      end
      if (rd_b) begin
        rdat_b_q <= in_b ? old_b : '0;
      end
      coll_q <= acc_a & acc_b & in_a & (bus.addr_a == bus.addr_b) & (bus.wen_a | bus.wen_b);
      oob_q  <= (acc_a & ~in_a) | (acc_b & ~in_b);
    end
  end

  tdpram_rd_pipe #(
    .DATA_W (DATA_W),
    .OUT_REG(OUT_REG)
  ) u_pipe_a (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rdat_a_q),
    .v_i   (rv_a_q),
    .q_o   (bus.q_a),
    .v_o   (bus.q_a_valid)
  );

  tdpram_rd_pipe #(
    .DATA_W (DATA_W),
    .OUT_REG(OUT_REG)
  ) u_pipe_b (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rdat_b_q),
    .v_i   (rv_b_q),
    .q_o   (bus.q_b),
    .v_o   (bus.q_b_valid)
  );

  assign bus.coll = coll_q;
  assign bus.oob  = oob_q;

endmodule

// File: tb/tb_tdpram_bank.sv
// Scoreboard bench for tdpram_bank: one instance with OUT_REG=1 and one with OUT_REG=0 share
// the same stimulus; a 6-bit address lets out-of-range words 32/33 be exercised.
module tb_tdpram_bank;

  localparam int unsigned DataW = 256;
  localparam int unsigned Depth = 32;
  localparam int unsigned AddrW = 6;
  localparam int unsigned NumCh = 4;  // 0/1: OUT_REG=1 ports A/B, 2/3: OUT_REG=0 ports A/B
  localparam logic [31:0] BeAll = 32'hffff_ffff;

  typedef logic [DataW-1:0] word_t;
  typedef struct {
    word_t       data;
    int unsigned cyc;
  } exp_t;
  typedef struct {
    logic        en;
    logic        wen;
    logic [31:0] be;
    int unsigned addr;
    word_t       d;
  } op_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr   = 1'b0;
  logic        done_r, done_n;
  logic        bank_rdy = 1'b0;
  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  word_t model    [Depth];
  exp_t  sb       [NumCh][$];
  word_t last_exp [NumCh];
  word_t q_obs    [NumCh];
  logic  v_obs    [NumCh];

  tdpram_bank_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus_r ();
  tdpram_bank_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus_n ();

  assign bus_n.en_a   = bus_r.en_a;
  assign bus_n.wen_a  = bus_r.wen_a;
  assign bus_n.be_a   = bus_r.be_a;
  assign bus_n.addr_a = bus_r.addr_a;
  assign bus_n.d_a    = bus_r.d_a;
  assign bus_n.en_b   = bus_r.en_b;
  assign bus_n.wen_b  = bus_r.wen_b;
  assign bus_n.be_b   = bus_r.be_b;
  assign bus_n.addr_b = bus_r.addr_b;
  assign bus_n.d_b    = bus_r.d_b;

  assign q_obs[0] = bus_r.q_a;
  assign q_obs[1] = bus_r.q_b;
  assign q_obs[2] = bus_n.q_a;
  assign q_obs[3] = bus_n.q_b;
  assign v_obs[0] = bus_r.q_a_valid;
  assign v_obs[1] = bus_r.q_b_valid;
  assign v_obs[2] = bus_n.q_a_valid;
  assign v_obs[3] = bus_n.q_b_valid;

  tdpram_bank #(
    .DATA_W (DataW),
    .DEPTH  (Depth),
    .ADDR_W (AddrW),
    .OUT_REG(1)
  ) u_dut_r (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (clr),
    .init_done_o(done_r),
    .bus        (bus_r)
  );

  tdpram_bank #(
    .DATA_W (DataW),
    .DEPTH  (Depth),
    .ADDR_W (AddrW),
    .OUT_REG(0)
  ) u_dut_n (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (clr),
    .init_done_o(done_n),
    .bus        (bus_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t rnd_word();
    word_t w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic op_t nop();
    op_t o;
    o.en = 1'b0; o.wen = 1'b0; o.be = '0; o.addr = 0; o.d = '0;
    return o;
  endfunction

  function automatic op_t rd(input int unsigned addr);
    op_t o;
    o = nop();
    o.en = 1'b1; o.addr = addr;
    return o;
  endfunction

  function automatic op_t wr(input int unsigned addr, input word_t d, input logic [31:0] be);
    op_t o;
    o.en = 1'b1; o.wen = 1'b1; o.be = be; o.addr = addr; o.d = d;
    return o;
  endfunction

  function automatic word_t lane_write(input word_t old, input word_t d, input logic [31:0] be);
    word_t w;
    w = old;
    for (int i = 0; i < 32; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
    return w;
  endfunction

  task automatic expect_rd(input int port, input word_t data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + 2;
    sb[port].push_back(e);
    e.cyc  = cyc + 1;
    sb[port + 2].push_back(e);
  endtask

  // One clock of traffic: predict results from the model, then check the flag pulses.
  task automatic drive(input op_t a, input op_t b);
    logic ina, inb, exp_coll, exp_oob;
    bus_r.en_a = a.en; bus_r.wen_a = a.wen; bus_r.be_a = a.be;
    bus_r.addr_a = a.addr[AddrW-1:0]; bus_r.d_a = a.d;
    bus_r.en_b = b.en; bus_r.wen_b = b.wen; bus_r.be_b = b.be;
    bus_r.addr_b = b.addr[AddrW-1:0]; bus_r.d_b = b.d;
    ina = (a.addr < Depth);
    inb = (b.addr < Depth);
    exp_coll = 1'b0;
    exp_oob  = 1'b0;
    if (bank_rdy) begin
      exp_coll = a.en && b.en && (a.addr == b.addr) && ina && (a.wen || b.wen);
      exp_oob  = (a.en && !ina) || (b.en && !inb);
      if (a.en && !a.wen) expect_rd(0, ina ? model[a.addr] : '0);
      if (b.en && !b.wen) expect_rd(1, inb ? model[b.addr] : '0);
      if (b.en && b.wen && inb) model[b.addr] = lane_write(model[b.addr], b.d, b.be);
      if (a.en && a.wen && ina) model[a.addr] = lane_write(model[a.addr], a.d, a.be);
    end
    @(posedge clk);
    #1;
    check("coll_r", bus_r.coll, exp_coll);
    check("coll_n", bus_n.coll, exp_coll);
    check("oob_r", bus_r.oob, exp_oob);
    check("oob_n", bus_n.oob, exp_oob);
  endtask

  task automatic check_reset_outputs();
    for (int ch = 0; ch < NumCh; ch++) begin
      check($sformatf("rst_q%0d", ch), q_obs[ch], '0);
      check($sformatf("rst_v%0d", ch), v_obs[ch], '0);
    end
    check("rst_coll", {bus_r.coll, bus_n.coll}, '0);
    check("rst_oob", {bus_r.oob, bus_n.oob}, '0);
    check("rst_done", {done_r, done_n}, '0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    for (int ch = 0; ch < NumCh; ch++) sb[ch].delete();
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    bank_rdy = 1'b0;
  endtask

  // Ignored traffic while the array is being zeroed; the lagging write address would survive.
  task automatic init_phase();
    for (int k = 1; k <= Depth; k++) begin
      drive(wr((k + Depth - 2) % Depth, rnd_word(), BeAll), rd(k % Depth));
      check("init_done_r", done_r, k == Depth);
      check("init_done_n", done_n, k == Depth);
    end
    bank_rdy = 1'b1;
    for (int i = 0; i < Depth; i++) model[i] = '0;
  endtask

  task automatic read_all();
    for (int i = 0; i < Depth; i++) drive(rd(i), rd(Depth - 1 - i));
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int ch = 0; ch < NumCh; ch++) begin
      if (!rst_n) last_exp[ch] = '0;
      if (v_obs[ch]) begin
        if (sb[ch].size() == 0) begin
          check($sformatf("unexpected_valid%0d", ch), 1, 0);
        end else begin
          e = sb[ch].pop_front();
          check($sformatf("rdata%0d", ch), q_obs[ch], e.data);
          check($sformatf("latency%0d", ch), cyc, e.cyc);
          last_exp[ch] = e.data;
        end
      end else begin
        check($sformatf("hold%0d", ch), q_obs[ch], last_exp[ch]);
      end
    end
  end

  initial begin
    op_t a, b;
    for (int ch = 0; ch < NumCh; ch++) last_exp[ch] = '0;
    bus_r.en_a = 1'b0; bus_r.wen_a = 1'b0; bus_r.be_a = '0; bus_r.addr_a = '0; bus_r.d_a = '0;
    bus_r.en_b = 1'b0; bus_r.wen_b = 1'b0; bus_r.be_b = '0; bus_r.addr_b = '0; bus_r.d_b = '0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_phase();
    read_all();

    drive(wr(1, word_t'(1337), BeAll), wr(3, word_t'(2022), BeAll));
    drive(rd(3), rd(1));
    drive(wr(2, word_t'(1338), BeAll), nop());
    drive(wr(4, {32{8'hAA}}, 32'h0000_ffff), wr(4, {32{8'h55}}, BeAll));
    drive(rd(4), nop());
    drive(wr(2, word_t'(2023), BeAll), rd(2));
    drive(rd(2), rd(2));
    drive(wr(6, rnd_word(), BeAll), nop());
    drive(nop(), rd(6));
    drive(wr(5, '1, '0), nop());
    drive(rd(5), rd(4));
    drive(rd(32), nop());
    drive(nop(), wr(32, rnd_word(), BeAll));
    drive(rd(0), rd(33));

    for (int n = 0; n < 80; n++) begin
      a = $urandom_range(0, 1) ? wr(0, rnd_word(), $urandom) : rd(0);
      b = $urandom_range(0, 1) ? wr(0, rnd_word(), $urandom) : rd(0);
      a.en = ($urandom_range(0, 3) != 0);
      b.en = ($urandom_range(0, 3) != 0);
      a.addr = $urandom_range(0, 9);
      b.addr = $urandom_range(0, 9);
      if (a.addr > 7) a.addr += 24;
      if (b.addr > 7) b.addr += 24;
      if (a.addr == b.addr && a.addr >= Depth) b.addr = 0;
      drive(a, b);
    end

    // Reads issued in the clr cycle still return pre-clear data.
    clr = 1'b1;
    drive(rd(1), rd(3));
    clr = 1'b0;
    bank_rdy = 1'b0;
    init_phase();
    read_all();

    for (int i = 0; i < 6; i++) drive(wr(i, rnd_word(), BeAll), nop());
    drive(rd(1), rd(2));
    reset_pulse();
    for (int k = 0; k < 10; k++) drive(wr(k, rnd_word(), BeAll), rd(k));
    check("mid_init_done", {done_r, done_n}, '0);
    reset_pulse();
    init_phase();
    read_all();

    for (int k = 0; k < 4; k++) drive(nop(), nop());
    for (int ch = 0; ch < NumCh; ch++) check($sformatf("sb_empty%0d", ch), sb[ch].size(), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
